// File: rtl/pwm_burst_scheduler_pkg.sv
// pwm_burst_scheduler_pkg: shared function codes, FSM states and command layout for the PWM burst scheduler
package pwm_burst_scheduler_pkg;
  localparam logic [7:0] FUNC_CFG_START = 8'h01;
  localparam logic [7:0] FUNC_STOP_CH = 8'h02;
  localparam logic [7:0] FUNC_STOP_ALL = 8'h03;
  localparam int CMD_FIXED_W = 48;
  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT_IDLE,
    S_LOAD,
    S_START
  } state_t;
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/pwm_burst_scheduler_fifo.sv
// sched_cmd_fifo: synchronous first-word-fall-through command queue; a push into a full queue is taken only when a pop frees a slot the same cycle
module sched_cmd_fifo import pwm_burst_scheduler_pkg::*; #(
  parameter int W = CMD_FIXED_W + 32,
  parameter int DEPTH = 4
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  // pointer and occupancy bookkeeping
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  // storage array, write-only on accepted pushes
  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/pwm_burst_scheduler.sv
// pwm_burst_scheduler: queues UART commands, waits for the target channel to idle, loads its config and holds pwm_en for the burst (optional WAIT_IDLE timeout: PWM_SCHED_TIMEOUT_EN)
module pwm_burst_scheduler import pwm_burst_scheduler_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int PAT_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic                        cmd_valid,
  input  logic [7:0]                  cmd_func,
  input  logic [7:0]                  cmd_ch,
  input  logic [7:0]                  cmd_duty,
  input  logic [15:0]                 cmd_dessert,
  input  logic [7:0]                  cmd_pulse_num,
  input  logic [PAT_WIDTH-1:0]        cmd_pat,
  input  logic [NUM_CH-1:0]           pwm_busy,
  input  logic [NUM_CH-1:0]           pwm_valid,
  output logic [NUM_CH-1:0]           pwm_en,
  output logic [NUM_CH*8-1:0]         cfg_duty,
  output logic [NUM_CH*16-1:0]        cfg_dessert,
  output logic [NUM_CH*8-1:0]         cfg_pulse_num,
  output logic [NUM_CH*PAT_WIDTH-1:0] cfg_pat,
  output logic                        sched_busy,
  output logic                        fifo_ovf,
  output logic [7:0]                  err_cnt
);
  localparam int CW = CMD_FIXED_W + PAT_WIDTH;
  state_t state, next;
  logic [CW-1:0] fifo_dout;
  logic fifo_full, fifo_empty;
  logic pop, load_we, start, stop_all, stop_ch, err_inc, timeout_hit;
  logic [7:0] cur_func, cur_ch, cur_duty, cur_pn;
  logic [15:0] cur_dessert;
  logic [PAT_WIDTH-1:0] cur_pat;
  logic [NUM_CH-1:0] ch_mask, en_next;
  logic ch_ok, func_ok, busy_sel, en_busy;

  sched_cmd_fifo #(.W(CW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .push(cmd_valid),
    .pop(pop),
    .din({cmd_func, cmd_ch, cmd_duty, cmd_dessert, cmd_pulse_num, cmd_pat}),
    .dout(fifo_dout),
    .full(fifo_full),
    .empty(fifo_empty)
  );

  assign ch_ok = cur_ch < 8'(NUM_CH);
  assign func_ok = cur_func inside {FUNC_CFG_START, FUNC_STOP_CH, FUNC_STOP_ALL};
  assign ch_mask = ch_ok ? NUM_CH'(1) << cur_ch : '0;
  assign busy_sel = |(pwm_busy & ch_mask);
  assign en_busy = |(pwm_en & pwm_busy & ch_mask);
  assign en_next = (stop_all ? '0 : pwm_en & ~pwm_valid & ~(stop_ch ? ch_mask : '0)) | (start ? ch_mask : '0);
  assign sched_busy = state != S_IDLE || !fifo_empty;

`ifdef PWM_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wcnt;
  // cycles spent in the current WAIT_IDLE visit
  always_ff @(posedge sys_clk) begin
    wcnt <= (sys_rst || state != S_WAIT_IDLE) ? '0 : wcnt + TW'(1);
  end
  assign timeout_hit = wcnt == TW'(TIMEOUT_CYC - 1);
`else
  assign timeout_hit = 1'b0 && (TIMEOUT_CYC != 0);
`endif

  // state register and the command currently being executed
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= S_IDLE;
      {cur_func, cur_ch, cur_duty, cur_dessert, cur_pn, cur_pat} <= '0;
    end else begin
      state <= next;
      if (pop) {cur_func, cur_ch, cur_duty, cur_dessert, cur_pn, cur_pat} <= fifo_dout;
    end
  end

  // next state and one-cycle action strobes
  always_comb begin
    next = state;
    pop = 1'b0;
    load_we = 1'b0;
    start = 1'b0;
    stop_all = 1'b0;
    stop_ch = 1'b0;
    err_inc = 1'b0;
    case (state)
      S_IDLE: begin
        pop = !fifo_empty;
        next = fifo_empty ? S_IDLE : S_DECODE;
      end
      S_DECODE: begin
        next = S_IDLE;
        if (cur_func == FUNC_STOP_ALL) stop_all = 1'b1;
        else if (!func_ok || !ch_ok) err_inc = 1'b1;
        else if (cur_func == FUNC_STOP_CH) stop_ch = 1'b1;
        else next = busy_sel ? S_WAIT_IDLE : S_LOAD;
      end
      S_WAIT_IDLE: begin
        if (!busy_sel) next = S_LOAD;
        else if (timeout_hit) begin
          err_inc = 1'b1;
          next = S_IDLE;
        end
      end
      S_LOAD: begin
        load_we = !en_busy;
        next = en_busy ? S_WAIT_IDLE : S_START;
      end
      S_START: begin
        start = 1'b1;
        next = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
  end

  // per-channel enables; a START on a channel overrides its end-of-burst clear
  always_ff @(posedge sys_clk) begin
    pwm_en <= sys_rst ? '0 : en_next;
  end

  // per-channel config slices, written only for the loaded channel
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cfg_duty <= '0;
      cfg_dessert <= '0;
      cfg_pulse_num <= '0;
      cfg_pat <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (load_we && ch_mask[k]) begin
          cfg_duty[k*8+:8] <= cur_duty;
          cfg_dessert[k*16+:16] <= cur_dessert;
          cfg_pulse_num[k*8+:8] <= cur_pn;
          cfg_pat[k*PAT_WIDTH+:PAT_WIDTH] <= cur_pat;
        end
      end
    end
  end

  // saturating error count and sticky overflow flag
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      err_cnt <= '0;
      fifo_ovf <= 1'b0;
    end else begin
      err_cnt <= err_inc ? sat_inc(err_cnt) : err_cnt;
      fifo_ovf <= fifo_ovf || (cmd_valid && fifo_full && !pop);
    end
  end
endmodule

// File: tb/tb_pwm_burst_scheduler.sv
// tb_pwm_burst_scheduler: directed self-checking bench for pwm_burst_scheduler
module tb_pwm_burst_scheduler;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic [7:0] cmd_func = '0, cmd_ch = '0, cmd_duty = '0, cmd_pulse_num = '0;
  logic [15:0] cmd_dessert = '0;
  logic [31:0] cmd_pat = '0;
  logic [3:0] pwm_busy = '0, pwm_valid = '0;
  logic [3:0] pwm_en;
  logic [31:0] cfg_duty, cfg_pulse_num;
  logic [63:0] cfg_dessert;
  logic [127:0] cfg_pat;
  logic sched_busy, fifo_ovf;
  logic [7:0] err_cnt;
  int checks = 0;
  int failures = 0;

  pwm_burst_scheduler dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cmd_valid(cmd_valid), .cmd_func(cmd_func),
    .cmd_ch(cmd_ch), .cmd_duty(cmd_duty), .cmd_dessert(cmd_dessert), .cmd_pulse_num(cmd_pulse_num),
    .cmd_pat(cmd_pat), .pwm_busy(pwm_busy), .pwm_valid(pwm_valid), .pwm_en(pwm_en),
    .cfg_duty(cfg_duty), .cfg_dessert(cfg_dessert), .cfg_pulse_num(cfg_pulse_num), .cfg_pat(cfg_pat),
    .sched_busy(sched_busy), .fifo_ovf(fifo_ovf), .err_cnt(err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired before the directed sequence completed");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] f, input logic [7:0] c, input logic [7:0] d,
                      input logic [15:0] ds, input logic [7:0] pn, input logic [31:0] p);
    cmd_func = f; cmd_ch = c; cmd_duty = d; cmd_dessert = ds; cmd_pulse_num = pn; cmd_pat = p;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] log_d [8];
    logic [7:0] prev0;
    int n, t0, t3;
    repeat (3) tick();
    sys_rst = 1'b0;
    chk("rst_pwm_en", 128'(pwm_en), 128'(4'b0000));
    chk("rst_cfg_duty", 128'(cfg_duty), 128'(32'h0));
    chk("rst_cfg_pat", cfg_pat, 128'h0);
    chk("rst_sched_busy", 128'(sched_busy), 128'(1'b0));
    chk("rst_ovf_err", 128'({fifo_ovf, err_cnt}), 128'(9'h000));

    send(8'h01, 8'd1, 8'h10, 16'h0020, 8'd3, 32'hA5A5A5A5);
    chk("t1_sched_busy", 128'(sched_busy), 128'(1'b1));
    tick(); tick();
    chk("t1_cfg_edge2", 128'(cfg_duty), 128'(32'h0));
    tick();
    chk("t1_cfg_duty_edge3", 128'(cfg_duty), 128'(32'h0000_1000));
    chk("t1_cfg_dessert", 128'(cfg_dessert), 128'(64'h0000_0000_0020_0000));
    chk("t1_cfg_pulse", 128'(cfg_pulse_num), 128'(32'h0000_0300));
    chk("t1_cfg_pat", cfg_pat, {32'h0, 32'h0, 32'hA5A5A5A5, 32'h0});
    chk("t1_en_edge3", 128'(pwm_en), 128'(4'b0000));
    tick();
    chk("t1_en_edge4", 128'(pwm_en), 128'(4'b0010));
    pwm_valid = 4'b0010;
    tick();
    pwm_valid = 4'b0000;
    chk("t1_en_cleared", 128'(pwm_en), 128'(4'b0000));

    pwm_busy = 4'b0100;
    send(8'h01, 8'd2, 8'h22, 16'h0044, 8'd5, 32'h12345678);
    repeat (49) tick();
    chk("t2_wait_cfg", 128'(cfg_duty), 128'(32'h0000_1000));
    chk("t2_wait_en", 128'(pwm_en), 128'(4'b0000));
    chk("t2_wait_busy", 128'(sched_busy), 128'(1'b1));
    pwm_busy = 4'b0000;
    tick();
    chk("t2_cfg_not_yet", 128'(cfg_duty), 128'(32'h0000_1000));
    tick();
    chk("t2_cfg_loaded", 128'(cfg_duty), 128'(32'h0022_1000));
    chk("t2_en_not_yet", 128'(pwm_en), 128'(4'b0000));
    tick();
    chk("t2_en_set", 128'(pwm_en), 128'(4'b0100));

    pwm_busy = 4'b1000;
    send(8'h01, 8'd3, 8'h33, 16'h0001, 8'd0, 32'hCAFEF00D);
    tick(); tick();
    for (int i = 1; i <= 6; i++) begin
      send(8'h01, 8'd0, 8'(i), 16'h0002, 8'd1, 32'h0);
      if (i == 4) chk("t3_ovf_at_full", 128'(fifo_ovf), 128'(1'b0));
    end
    chk("t3_ovf_set", 128'(fifo_ovf), 128'(1'b1));
    pwm_busy = 4'b0000;
    n = 0; t0 = -1; t3 = -1; prev0 = 8'h00;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (cfg_duty[7:0] != prev0) begin
        if (n < 8) log_d[n] = cfg_duty[7:0];
        if (t0 < 0) t0 = c;
        n++;
        prev0 = cfg_duty[7:0];
      end
      if (t3 < 0 && cfg_duty[31:24] == 8'h33) t3 = c;
    end
    chk("t3_exec_count", 128'(n), 128'(4));
    chk("t3_order", 128'({log_d[0], log_d[1], log_d[2], log_d[3]}), 128'(32'h01020304));
    chk("t3_ch3_first", 128'(t3 >= 0 && t3 < t0), 128'(1'b1));
    chk("t3_en", 128'(pwm_en), 128'(4'b1101));
    chk("t3_idle", 128'(sched_busy), 128'(1'b0));

    send(8'h07, 8'd0, 8'h99, 16'h0, 8'd1, 32'h0);
    tick(); tick(); tick();
    send(8'h01, 8'd5, 8'h55, 16'h0, 8'd1, 32'h0);
    tick(); tick(); tick();
    chk("t4_err_cnt", 128'(err_cnt), 128'(8'd2));
    chk("t4_en", 128'(pwm_en), 128'(4'b1101));
    chk("t4_cfg", 128'(cfg_duty), 128'(32'h3322_1004));

    send(8'h02, 8'd2, 8'h0, 16'h0, 8'd0, 32'h0);
    tick(); tick(); tick();
    chk("t5_stop_ch", 128'(pwm_en), 128'(4'b1001));
    send(8'h01, 8'd1, 8'h11, 16'h0, 8'd1, 32'h0);
    tick(); tick(); tick(); tick();
    chk("t5_en_1011", 128'(pwm_en), 128'(4'b1011));
    chk("t5_cfg", 128'(cfg_duty), 128'(32'h3322_1104));
    send(8'h03, 8'd0, 8'h0, 16'h0, 8'd0, 32'h0);
    tick();
    chk("t5_stop_all_pop", 128'(pwm_en), 128'(4'b1011));
    tick();
    chk("t5_stop_all", 128'(pwm_en), 128'(4'b0000));

    send(8'h01, 8'd0, 8'h77, 16'h0, 8'd1, 32'h0);
    tick(); tick(); tick();
    pwm_valid = 4'b0001;
    tick();
    pwm_valid = 4'b0000;
    chk("t6_start_wins", 128'(pwm_en), 128'(4'b0001));
    tick();
    chk("t6_start_hold", 128'(pwm_en), 128'(4'b0001));

    for (int i = 0; i < 260; i++) begin
      send(8'h00, 8'd0, 8'h0, 16'h0, 8'd0, 32'h0);
      tick(); tick(); tick();
    end
    chk("t7_err_sat", 128'(err_cnt), 128'(8'hFF));
    chk("t7_en_kept", 128'(pwm_en), 128'(4'b0001));

    pwm_busy = 4'b0001;
    sys_rst = 1'b1;
    tick();
    chk("t8_rst_en", 128'(pwm_en), 128'(4'b0000));
    chk("t8_rst_cfg", 128'({cfg_duty, cfg_pulse_num, cfg_dessert}), 128'h0);
    chk("t8_rst_pat", cfg_pat, 128'h0);
    chk("t8_rst_flags", 128'({sched_busy, fifo_ovf, err_cnt}), 128'(10'h000));
    sys_rst = 1'b0;
    pwm_busy = 4'b0000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
